// File: rtl/dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// dual_port_ram_param
//   Single-clock true dual-port RAM shared by two masters. Each port can read
//   or write any word every cycle, with byte enables, a configurable read
//   latency (1 or 2), defined same-address collision behaviour and an optional
//   post-reset clear sweep that zeroes every location before requests are
//   accepted.
//
// Parameters
//   DATA_W      word width in bits (multiple of 8)
//   ADDR_W      address width; DEPTH = 2**ADDR_W
//   RD_LAT      read latency in cycles, 1 or 2
//   RW_MODE     same-cycle cross-port read of a written word: 0 old, 1 new
//   A_PRIORITY  write-write collision winner on shared bytes: 1 A, 0 B
//   CLEAR_INIT  1 = zero the whole array after reset before going ready
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   init_done                high once requests are accepted
//   x_chipselect, x_wr_en    request strobe, 1 = write / 0 = read
//   x_outenable              combinational gate on x_dataout
//   x_be, x_address, x_data  byte enables, word address, write data
//   x_dataout, x_valid       held read word, one-cycle result strobe
//   collision                one-cycle pulse after a same-address pair
//                            in which at least one port wrote
// -----------------------------------------------------------------------------
module dual_port_ram_param #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RW_MODE    = 0,
    parameter int unsigned A_PRIORITY = 1,
    parameter int unsigned CLEAR_INIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,

    input  logic                a_chipselect,
    input  logic                a_wr_en,
    input  logic                a_outenable,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W-1:0]   a_data,
    output logic [DATA_W-1:0]   a_dataout,
    output logic                a_valid,

    input  logic                b_chipselect,
    input  logic                b_wr_en,
    input  logic                b_outenable,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W-1:0]   b_data,
    output logic [DATA_W-1:0]   b_dataout,
    output logic                b_valid,

    output logic                collision
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BE_W  = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Overlay the enabled bytes of wdat onto base.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] wdat,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = base;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Storage and control state
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              collision_q, collision_d;
    logic              a_valid_q,   a_valid_d;
    logic              b_valid_q,   b_valid_d;
    logic [DATA_W-1:0] a_dout_q,    a_dout_d;
    logic [DATA_W-1:0] b_dout_q,    b_dout_d;

    // Qualified requests and per-port write masks
    logic              a_rd, a_wr, b_rd, b_wr;
    logic              same_addr;
    logic [BE_W-1:0]   a_wbe, b_wbe;
    logic [DATA_W-1:0] a_rword, b_rword;

    // Result presented to the output stage, after any extra latency
    logic              a_res_vld, b_res_vld;
    logic [DATA_W-1:0] a_res_dat, b_res_dat;

    // Request decode; nothing is accepted until the clear sweep has finished.
    always_comb begin : req_decode
        a_rd      = init_done_q & a_chipselect & ~a_wr_en;
        a_wr      = init_done_q & a_chipselect &  a_wr_en;
        b_rd      = init_done_q & b_chipselect & ~b_wr_en;
        b_wr      = init_done_q & b_chipselect &  b_wr_en;
        same_addr = (a_address == b_address);
    end

    // Effective byte masks: on a write-write hit the loser drops shared bytes,
    // so the two ports never drive the same byte in one cycle.
    always_comb begin : write_masks
        a_wbe = a_wr ? a_be : '0;
        b_wbe = b_wr ? b_be : '0;
        if (a_wr && b_wr && same_addr) begin
            if (A_PRIORITY != 0) begin
                b_wbe = b_be & ~a_be;
            end else begin
                a_wbe = a_be & ~b_be;
            end
        end
    end

    // Array read; in write-first mode a reader sees the other port's bytes.
    always_comb begin : read_words
        a_rword = mem_q[a_address];
        b_rword = mem_q[b_address];
        if ((RW_MODE != 0) && b_wr && same_addr) begin
            a_rword = merge_bytes(a_rword, b_data, b_wbe);
        end
        if ((RW_MODE != 0) && a_wr && same_addr) begin
            b_rword = merge_bytes(b_rword, a_data, a_wbe);
        end
    end

    // Memory array: clear sweep plus byte-masked port writes.
    always_ff @(posedge clk) begin : mem_write
        if (state_q == ST_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (a_wbe[i]) begin
                mem_q[a_address][8*i +: 8] <= a_data[8*i +: 8];
            end
            if (b_wbe[i]) begin
                mem_q[b_address][8*i +: 8] <= b_data[8*i +: 8];
            end
        end
    end

    // Optional second read stage.
    if (RD_LAT == 2) begin : g_lat2
        logic              a_p1_vld_q, a_p1_vld_d;
        logic              b_p1_vld_q, b_p1_vld_d;
        logic [DATA_W-1:0] a_p1_dat_q, a_p1_dat_d;
        logic [DATA_W-1:0] b_p1_dat_q, b_p1_dat_d;

        always_comb begin : p1_next
            a_p1_vld_d = a_rd;
            b_p1_vld_d = b_rd;
            a_p1_dat_d = a_rword;
            b_p1_dat_d = b_rword;
        end

        always_ff @(posedge clk or posedge rst) begin : p1_regs
            if (rst) begin
                a_p1_vld_q <= 1'b0;
                b_p1_vld_q <= 1'b0;
                a_p1_dat_q <= '0;
                b_p1_dat_q <= '0;
            end else begin
                a_p1_vld_q <= a_p1_vld_d;
                b_p1_vld_q <= b_p1_vld_d;
                a_p1_dat_q <= a_p1_dat_d;
                b_p1_dat_q <= b_p1_dat_d;
            end
        end

        assign a_res_vld = a_p1_vld_q;
        assign b_res_vld = b_p1_vld_q;
        assign a_res_dat = a_p1_dat_q;
        assign b_res_dat = b_p1_dat_q;
    end else begin : g_lat1
        assign a_res_vld = a_rd;
        assign b_res_vld = b_rd;
        assign a_res_dat = a_rword;
        assign b_res_dat = b_rword;
    end

    // Next-state: clear sweep, readiness, output stage and collision flag.
    always_comb begin : ctrl_next
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;

        unique case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                init_done_d = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        // The output word holds between results.
        a_valid_d = a_res_vld;
        b_valid_d = b_res_vld;
        a_dout_d  = a_res_vld ? a_res_dat : a_dout_q;
        b_dout_d  = b_res_vld ? b_res_dat : b_dout_q;

        // Two reads of one word are not a conflict.
        collision_d = init_done_q & a_chipselect & b_chipselect & same_addr
                      & (a_wr_en | b_wr_en);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin : ctrl_regs
        if (rst) begin
            state_q     <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            collision_q <= 1'b0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            collision_q <= collision_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
        end
    end

    // Output enables gate the held word combinationally.
    assign a_dataout = a_outenable ? a_dout_q : '0;
    assign b_dataout = b_outenable ? b_dout_q : '0;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;
    assign init_done = init_done_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_param
//   Two instances driven by the same stimulus:
//     u0: RD_LAT=1, RW_MODE=0, A_PRIORITY=1
//     u1: RD_LAT=2, RW_MODE=1, A_PRIORITY=0
//   A word-level reference model (array + scheduled results) predicts every
//   output each cycle; directed scenarios add fixed-value checks.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_cs = 0, a_we = 0, a_oe = 0;
    logic [3:0]    a_be = 0;
    logic [AW-1:0] a_ad = 0;
    logic [DW-1:0] a_dt = 0;
    logic          b_cs = 0, b_we = 0, b_oe = 0;
    logic [3:0]    b_be = 0;
    logic [AW-1:0] b_ad = 0;
    logic [DW-1:0] b_dt = 0;

    logic          d_init [2];
    logic          d_coll [2];
    logic          d_av   [2];
    logic          d_bv   [2];
    logic [DW-1:0] d_ad   [2];
    logic [DW-1:0] d_bd   [2];

    always #5 clk = ~clk;

    dual_port_ram_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .RW_MODE(0),
        .A_PRIORITY(1), .CLEAR_INIT(1)
    ) u0 (
        .clk(clk), .rst(rst), .init_done(d_init[0]),
        .a_chipselect(a_cs), .a_wr_en(a_we), .a_outenable(a_oe), .a_be(a_be),
        .a_address(a_ad), .a_data(a_dt), .a_dataout(d_ad[0]), .a_valid(d_av[0]),
        .b_chipselect(b_cs), .b_wr_en(b_we), .b_outenable(b_oe), .b_be(b_be),
        .b_address(b_ad), .b_data(b_dt), .b_dataout(d_bd[0]), .b_valid(d_bv[0]),
        .collision(d_coll[0])
    );

    dual_port_ram_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .RW_MODE(1),
        .A_PRIORITY(0), .CLEAR_INIT(1)
    ) u1 (
        .clk(clk), .rst(rst), .init_done(d_init[1]),
        .a_chipselect(a_cs), .a_wr_en(a_we), .a_outenable(a_oe), .a_be(a_be),
        .a_address(a_ad), .a_data(a_dt), .a_dataout(d_ad[1]), .a_valid(d_av[1]),
        .b_chipselect(b_cs), .b_wr_en(b_we), .b_outenable(b_oe), .b_be(b_be),
        .b_address(b_ad), .b_data(b_dt), .b_dataout(d_bd[1]), .b_valid(d_bv[1]),
        .collision(d_coll[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Per-instance configuration
    function automatic int lat(input int k);  return (k == 0) ? 1 : 2; endfunction
    function automatic bit rwm(input int k);  return (k == 0) ? 1'b0 : 1'b1; endfunction
    function automatic bit apri(input int k); return (k == 0) ? 1'b1 : 1'b0; endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference model state
    logic [31:0] mm   [2][DEPTH];
    bit          sv   [2][2][4];
    logic [31:0] sd   [2][2][4];
    logic [31:0] held [2][2];
    bit          ev   [2][2];
    bit          ecol [2];
    int          since_rst = 0;
    int          ecyc = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
            for (int p = 0; p < 2; p++) begin
                held[k][p] = '0;
                ev[k][p]   = 1'b0;
                for (int s = 0; s < 4; s++) sv[k][p][s] = 1'b0;
            end
            ecol[k] = 1'b0;
        end
        since_rst = 0;
    endtask

    task automatic sched(input int k, input int p, input int due, input logic [31:0] d);
        sv[k][p][due % 4] = 1'b1;
        sd[k][p][due % 4] = d;
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_edge();
        bit ready;
        ready = (since_rst >= DEPTH);
        since_rst++;
        ecyc++;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] oa, ob;
            bit same, aw, bw;
            ecol[k] = 1'b0;
            if (ready) begin
                oa   = mm[k][a_ad];
                ob   = mm[k][b_ad];
                same = (a_ad == b_ad);
                aw   = a_cs && a_we;
                bw   = b_cs && b_we;
                if (a_cs && !a_we)
                    sched(k, 0, ecyc + lat(k) - 1, (rwm(k) && bw && same) ? merge(oa, b_dt, b_be) : oa);
                if (b_cs && !b_we)
                    sched(k, 1, ecyc + lat(k) - 1, (rwm(k) && aw && same) ? merge(ob, a_dt, a_be) : ob);
                if (aw && bw && same) begin
                    if (apri(k)) mm[k][a_ad] = merge(merge(oa, b_dt, b_be), a_dt, a_be);
                    else         mm[k][a_ad] = merge(merge(oa, a_dt, a_be), b_dt, b_be);
                end else begin
                    if (aw) mm[k][a_ad] = merge(mm[k][a_ad], a_dt, a_be);
                    if (bw) mm[k][b_ad] = merge(mm[k][b_ad], b_dt, b_be);
                end
                ecol[k] = a_cs && b_cs && same && (a_we || b_we);
            end
            for (int p = 0; p < 2; p++) begin
                ev[k][p] = sv[k][p][ecyc % 4];
                if (ev[k][p]) held[k][p] = sd[k][p][ecyc % 4];
                sv[k][p][ecyc % 4] = 1'b0;
            end
        end
    endtask

    task automatic check_outs(input string ph);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.u%0d.init", ph, k), 32'(d_init[k]), 32'(since_rst >= DEPTH));
            chk($sformatf("%s.u%0d.coll", ph, k), 32'(d_coll[k]), 32'(ecol[k]));
            chk($sformatf("%s.u%0d.av", ph, k),   32'(d_av[k]),   32'(ev[k][0]));
            chk($sformatf("%s.u%0d.bv", ph, k),   32'(d_bv[k]),   32'(ev[k][1]));
            chk($sformatf("%s.u%0d.ad", ph, k),   d_ad[k], a_oe ? held[k][0] : 32'h0);
            chk($sformatf("%s.u%0d.bd", ph, k),   d_bd[k], b_oe ? held[k][1] : 32'h0);
        end
    endtask

    // One clock: predict, let the edge happen, compare, return at negedge.
    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        check_outs(ph);
        @(negedge clk);
    endtask

    task automatic idle();
        a_cs = 0; a_we = 0; a_be = 0;
        b_cs = 0; b_we = 0; b_be = 0;
    endtask

    task automatic rand_req(input int amax);
        a_cs = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
        b_cs = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
        a_be = 4'($urandom);             b_be = 4'($urandom);
        a_ad = AW'($urandom_range(0, amax)); b_ad = AW'($urandom_range(0, amax));
        a_dt = $urandom;                 b_dt = $urandom;
        a_oe = 1'(($urandom % 4) != 0);  b_oe = 1'(($urandom % 4) != 0);
    endtask

    // Assert reset now, check outputs drop at once, release and time the clear.
    task automatic reset_and_clear(input string ph);
        int n;
        a_oe = 1; b_oe = 1;
        rst  = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.rst.u%0d.init", ph, k), 32'(d_init[k]), 32'h0);
            chk($sformatf("%s.rst.u%0d.coll", ph, k), 32'(d_coll[k]), 32'h0);
            chk($sformatf("%s.rst.u%0d.av", ph, k),   32'(d_av[k]),   32'h0);
            chk($sformatf("%s.rst.u%0d.bv", ph, k),   32'(d_bv[k]),   32'h0);
            chk($sformatf("%s.rst.u%0d.ad", ph, k),   d_ad[k], 32'h0);
            chk($sformatf("%s.rst.u%0d.bd", ph, k),   d_bd[k], 32'h0);
        end
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b0;
        n = 0;
        // Requests during the sweep must be ignored.
        while (!d_init[0] && n < 200) begin
            rand_req(DEPTH - 1);
            tick({ph, ".clr"});
            n++;
        end
        chk({ph, ".clear_cycles"}, 32'(n), 32'd64);
        idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // 1: clear timing, then every address reads zero
        reset_and_clear("t1");
        a_oe = 1; b_oe = 1;
        for (int i = 0; i < DEPTH; i++) begin
            a_cs = 1; a_we = 0; a_ad = AW'(i);
            b_cs = 1; b_we = 0; b_ad = AW'(DEPTH - 1 - i);
            tick("t1.rd");
        end
        idle(); tick("t1.rd"); tick("t1.rd");

        // 2: write then read on the other port, both latencies
        a_cs = 1; a_we = 1; a_be = 4'hF; a_ad = 5; a_dt = 32'hDEADBEEF;
        tick("t2");
        idle(); b_cs = 1; b_we = 0; b_ad = 5;
        tick("t2");
        chk("t2.u0.bv_lat1", 32'(d_bv[0]), 32'h1);
        chk("t2.u1.bv_lat1", 32'(d_bv[1]), 32'h0);
        idle();
        tick("t2");
        chk("t2.u0.bv_lat2", 32'(d_bv[0]), 32'h0);
        chk("t2.u1.bv_lat2", 32'(d_bv[1]), 32'h1);
        chk("t2.u0.bd", d_bd[0], 32'hDEADBEEF);
        chk("t2.u1.bd", d_bd[1], 32'hDEADBEEF);

        // 3: write-write collision with byte enables
        a_cs = 1; a_we = 1; a_be = 4'h3; a_ad = 9; a_dt = 32'h11111111;
        b_cs = 1; b_we = 1; b_be = 4'h6; b_ad = 9; b_dt = 32'h22222222;
        tick("t3");
        chk("t3.u0.coll_hi", 32'(d_coll[0]), 32'h1);
        idle();
        tick("t3");
        chk("t3.u0.coll_lo", 32'(d_coll[0]), 32'h0);
        a_cs = 1; a_we = 0; a_ad = 9; a_oe = 1;
        tick("t3");
        idle();
        tick("t3");
        chk("t3.u0.word", d_ad[0], 32'h00221111);
        chk("t3.u1.word", d_ad[1], 32'h00222211);

        // 4: read-write collision, old vs new data
        a_cs = 1; a_we = 1; a_be = 4'hF; a_ad = 3; a_dt = 32'hAAAAAAAA;
        tick("t4");
        a_dt = 32'h55555555;
        b_cs = 1; b_we = 0; b_ad = 3;
        tick("t4");
        idle();
        tick("t4");
        chk("t4.u0.old", d_bd[0], 32'hAAAAAAAA);
        chk("t4.u1.new", d_bd[1], 32'h55555555);

        // 5: output enable gating of the held word
        a_oe = 0; a_cs = 1; a_we = 0; a_ad = 5;
        tick("t5");
        chk("t5.u0.av_gated", 32'(d_av[0]), 32'h1);
        chk("t5.u0.ad_gated", d_ad[0], 32'h0);
        idle();
        a_oe = 1;
        #1;
        chk("t5.u0.ad_oe", d_ad[0], 32'hDEADBEEF);
        tick("t5");
        chk("t5.u1.ad_oe", d_ad[1], 32'hDEADBEEF);

        // Random traffic concentrated on a few addresses to force collisions
        for (int i = 0; i < 1500; i++) begin
            rand_req(7);
            tick("rnd");
        end

        // Reset in READY with a read result in flight
        idle(); a_cs = 1; a_we = 0; a_ad = 3;
        tick("t6a");
        reset_and_clear("t6a");

        // 6: reset part way through the clear sweep restarts it
        model_reset();
        a_oe = 1; b_oe = 1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick("t6.pre");
        reset_and_clear("t6");

        // Memory is zero again after the second clear
        a_oe = 1; b_oe = 1;
        for (int i = 0; i < 8; i++) begin
            a_cs = 1; a_we = 0; a_ad = AW'(i);
            b_cs = 1; b_we = 0; b_ad = AW'(i + 8);
            tick("t6.rd");
        end
        idle(); tick("t6.rd"); tick("t6.rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
